// File: rtl/imul_issue_sched.sv
// Issue scheduler and writeback sequencer for the shared integer multiplier.
// Arbitrates two issue slots, tracks tags through the fixed-latency pipe and serialises long ops.
module imul_issue_sched #(
    parameter int         LAT      = 3,
    parameter int         LONG_LAT = 8,
    parameter int         TAGW     = 9,
    parameter logic [7:0] LONG_OPC = 8'h5A
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_vld,
    input  logic [12:0]     req0_op,
    input  logic [TAGW-1:0] req0_tag,
    output logic            req0_rdy,
    input  logic            req1_vld,
    input  logic [12:0]     req1_op,
    input  logic [TAGW-1:0] req1_tag,
    output logic            req1_rdy,
    input  logic            wb_stall,
    input  logic            flush,
    output logic            mul_clkEn,
    output logic            mul_en,
    output logic [12:0]     mul_op,
    output logic            mul_sel,
    output logic            wb_vld,
    output logic [TAGW-1:0] wb_tag,
    output logic            wb_src
);

    localparam int CNTW = (LONG_LAT > 2) ? $clog2(LONG_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PIPE  = 2'd1,
        DRAIN = 2'd2,
        LONG  = 2'd3
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   long_cnt;
    logic              rr_ptr;
    logic              drain_slot;
    logic [TAGW-1:0]   long_tag;
    logic              long_src;

    logic [LAT-1:0]    pipe_vld;
    logic [TAGW-1:0]   pipe_tag [LAT];
    logic [LAT-1:0]    pipe_src;

    logic              req0_long;
    logic              req1_long;
    logic              win_vld;
    logic              winner;
    logic              win_long;
    logic              drained;
    logic              can_issue;
    logic              drain_go;
    logic              grant0;
    logic              grant1;
    logic              grant_long;
    logic [TAGW-1:0]   grant_tag;
    logic              long_done;

    assign req0_long = (req0_op[7:0] == LONG_OPC);
    assign req1_long = (req1_op[7:0] == LONG_OPC);

    // rr_ptr names the slot preferred when both request.
    assign win_vld   = req0_vld | req1_vld;
    assign winner    = (req0_vld & req1_vld) ? rr_ptr : req1_vld;
    assign win_long  = winner ? req1_long : req0_long;

    // The last stage always leaves on an enabled cycle, so only the earlier
    // stages have to be empty before a long op may take the unit.
    assign drained   = ~|pipe_vld[LAT-2:0];
    assign can_issue = ~rst & ~flush & ~wb_stall;
    assign drain_go  = drain_slot ? (req1_vld & req1_long) : (req0_vld & req0_long);

    // Handshake: a request transfers in the cycle reqN_vld & reqN_rdy are
    // both high; rdy never depends on itself and at most one slot is ready.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_issue) begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant0 = ~winner;
                        grant1 = winner;
                    end
                end
                PIPE: begin
                    if (win_vld && !win_long) begin
                        grant0 = ~winner;
                        grant1 = winner;
                    end
                end
                DRAIN: begin
                    if (drained && drain_go) begin
                        grant0 = ~drain_slot;
                        grant1 = drain_slot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req0_rdy   = grant0;
    assign req1_rdy   = grant1;
    assign mul_en     = grant0 | grant1;
    assign mul_sel    = grant1;
    assign mul_op     = grant1 ? req1_op : (grant0 ? req0_op : 13'd0);
    assign grant_long = grant1 ? req1_long : (grant0 & req0_long);
    assign grant_tag  = grant1 ? req1_tag : req0_tag;
    assign mul_clkEn  = ~wb_stall;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= IDLE;
            long_cnt   <= '0;
            pipe_vld   <= '0;
            drain_slot <= 1'b0;
            long_tag   <= '0;
            long_src   <= 1'b0;
            if (rst) begin
                rr_ptr <= 1'b0;
            end
        end else begin
            if (mul_en) begin
                rr_ptr <= ~mul_sel;
            end
            if (!wb_stall) begin
                // Long ops never enter the tag pipe; they are tracked by long_*.
                pipe_vld <= {pipe_vld[LAT-2:0], mul_en & ~grant_long};
                pipe_src <= {pipe_src[LAT-2:0], mul_sel};
                pipe_tag[0] <= grant_tag;
                for (int i = 1; i < LAT; i++) begin
                    pipe_tag[i] <= pipe_tag[i-1];
                end

                case (state)
                    IDLE: begin
                        if (mul_en) begin
                            state <= grant_long ? LONG : PIPE;
                        end
                    end
                    PIPE: begin
                        if (mul_en) begin
                            state <= PIPE;
                        end else if (win_vld && win_long) begin
                            state      <= DRAIN;
                            drain_slot <= winner;
                        end else if (drained) begin
                            state <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (mul_en) begin
                            state <= LONG;
                        end else if (drained && !drain_go) begin
                            state <= PIPE;
                        end
                    end
                    LONG: begin
                        if (long_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            long_cnt <= long_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (mul_en && grant_long) begin
                    long_cnt <= CNTW'(LONG_LAT - 1);
                    long_tag <= grant_tag;
                    long_src <= mul_sel;
                end
            end
        end
    end

    // The pipe is always empty while a long op owns the unit, so the two
    // writeback sources never collide.
    assign long_done = (state == LONG) && (long_cnt == '0);
    assign wb_vld    = pipe_vld[LAT-1] | long_done;
    assign wb_tag    = long_done ? long_tag :
                       (pipe_vld[LAT-1] ? pipe_tag[LAT-1] : '0);
    assign wb_src    = long_done ? long_src :
                       (pipe_vld[LAT-1] & pipe_src[LAT-1]);

endmodule

// File: tb/tb_imul_issue_sched.sv
// Bench for imul_issue_sched: directed cycle table, then random traffic
// checked against a due-time model of the multiply unit.
module tb_imul_issue_sched;
  localparam int         LAT      = 3;
  localparam int         LONG_LAT = 8;
  localparam int         TAGW     = 9;
  localparam logic [7:0] LONG_OPC = 8'h5A;
  localparam int         N_RAND   = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_vld, req1_vld;
  logic [12:0]     req0_op, req1_op;
  logic [TAGW-1:0] req0_tag, req1_tag;
  logic            req0_rdy, req1_rdy;
  logic            wb_stall, flush;
  logic            mul_clkEn, mul_en, mul_sel;
  logic [12:0]     mul_op;
  logic            wb_vld, wb_src;
  logic [TAGW-1:0] wb_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imul_issue_sched #(.LAT(LAT), .LONG_LAT(LONG_LAT), .TAGW(TAGW), .LONG_OPC(LONG_OPC)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_op(req0_op), .req0_tag(req0_tag), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_op(req1_op), .req1_tag(req1_tag), .req1_rdy(req1_rdy),
    .wb_stall(wb_stall), .flush(flush), .mul_clkEn(mul_clkEn), .mul_en(mul_en),
    .mul_op(mul_op), .mul_sel(mul_sel), .wb_vld(wb_vld), .wb_tag(wb_tag), .wb_src(wb_src)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] wb_act();
    return wb_vld ? {21'd0, 1'b1, wb_tag, wb_src} : 32'd0;
  endfunction

  function automatic logic [31:0] wb_pack(input logic v, input logic [TAGW-1:0] t, input logic s);
    return v ? {21'd0, 1'b1, t, s} : 32'd0;
  endfunction

  task automatic chk_all(input string tag, input logic er0, input logic er1,
                         input logic [12:0] eop, input logic ewv,
                         input logic [TAGW-1:0] ewt, input logic ews);
    chk({tag, ".rdy"}, {30'd0, req1_rdy, req0_rdy}, {30'd0, er1, er0});
    chk({tag, ".mul_en"}, {31'd0, mul_en}, {31'd0, er0 | er1});
    chk({tag, ".mul_op"}, {19'd0, mul_op}, {19'd0, eop});
    chk({tag, ".mul_sel"}, {31'd0, mul_sel}, {31'd0, er1});
    chk({tag, ".wb"}, wb_act(), wb_pack(ewv, ewt, ews));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic rs, fl, st;
    logic v0; logic [12:0] o0; logic [TAGW-1:0] t0;
    logic v1; logic [12:0] o1; logic [TAGW-1:0] t1;
    logic er0, er1;
    logic ewv; logic [TAGW-1:0] ewt; logic ews;
  } vec_t;
  vec_t vecs[$];

  task automatic v(input logic rs, input logic fl, input logic st,
                   input logic v0, input logic [12:0] o0, input logic [TAGW-1:0] t0,
                   input logic v1, input logic [12:0] o1, input logic [TAGW-1:0] t1,
                   input logic er0, input logic er1,
                   input logic ewv, input logic [TAGW-1:0] ewt, input logic ews);
    vec_t r;
    r.rs = rs; r.fl = fl; r.st = st;
    r.v0 = v0; r.o0 = o0; r.t0 = t0;
    r.v1 = v1; r.o1 = o1; r.t1 = t1;
    r.er0 = er0; r.er1 = er1;
    r.ewv = ewv; r.ewt = ewt; r.ews = ews;
    vecs.push_back(r);
  endtask

  task automatic nop(input logic ewv, input logic [TAGW-1:0] ewt, input logic ews);
    v(0, 0, 0, 0, 13'd0, '0, 0, 13'd0, '0, 0, 0, ewv, ewt, ews);
  endtask

  task automatic build_table();
    logic [12:0] s, l;
    s = 13'h001;
    l = 13'h05A;
    // round robin from reset, slot 0 first
    v(0,0,0, 1,13'h002,9'h0A0, 1,13'h003,9'h0B0, 1,0, 0,'0,0);
    v(0,0,0, 1,13'h002,9'h0A1, 1,13'h003,9'h0B0, 0,1, 0,'0,0);
    v(0,0,0, 1,13'h002,9'h0A1, 1,13'h003,9'h0B1, 1,0, 0,'0,0);
    v(0,0,0, 1,13'h002,9'h0A2, 1,13'h003,9'h0B1, 0,1, 1,9'h0A0,0);
    nop(1,9'h0B0,1); nop(1,9'h0A1,0); nop(1,9'h0B1,1);
    // single short op, result LAT cycles later
    v(0,0,0, 1,s,9'h011, 0,13'd0,'0, 1,0, 0,'0,0);
    nop(0,'0,0); nop(0,'0,0); nop(1,9'h011,0);
    // stall with three ops in flight
    v(0,0,0, 0,13'd0,'0, 1,s,9'h0C1, 0,1, 0,'0,0);
    v(0,0,0, 1,s,9'h0C2, 0,13'd0,'0, 1,0, 0,'0,0);
    v(0,0,0, 0,13'd0,'0, 1,s,9'h0C3, 0,1, 0,'0,0);
    v(0,0,1, 1,s,9'h0C4, 0,13'd0,'0, 0,0, 1,9'h0C1,1);
    v(0,0,1, 1,s,9'h0C4, 0,13'd0,'0, 0,0, 1,9'h0C1,1);
    v(0,0,0, 1,s,9'h0C4, 0,13'd0,'0, 1,0, 1,9'h0C1,1);
    nop(1,9'h0C2,0); nop(1,9'h0C3,1); nop(1,9'h0C4,0);
    // long after short: drain, issue, exclusive use
    v(0,0,0, 1,s,9'h001, 0,13'd0,'0, 1,0, 0,'0,0);
    v(0,0,0, 0,13'd0,'0, 1,l,9'h002, 0,0, 0,'0,0);
    v(0,0,0, 0,13'd0,'0, 1,l,9'h002, 0,0, 0,'0,0);
    v(0,0,0, 0,13'd0,'0, 1,l,9'h002, 0,1, 1,9'h001,0);
    for (int i = 0; i < LONG_LAT - 1; i++)
      v(0,0,0, 1,s,9'h003, 0,13'd0,'0, 0,0, 0,'0,0);
    v(0,0,0, 1,s,9'h003, 0,13'd0,'0, 0,0, 1,9'h002,1);
    v(0,0,0, 1,s,9'h003, 0,13'd0,'0, 1,0, 0,'0,0);
    nop(0,'0,0); nop(0,'0,0); nop(1,9'h003,0);
    // flush two short ops in flight
    v(0,0,0, 1,s,9'h0D1, 0,13'd0,'0, 1,0, 0,'0,0);
    v(0,0,0, 0,13'd0,'0, 1,s,9'h0D2, 0,1, 0,'0,0);
    v(0,1,0, 1,s,9'h0D3, 0,13'd0,'0, 0,0, 0,'0,0);
    v(0,0,0, 1,s,9'h0D3, 0,13'd0,'0, 1,0, 0,'0,0);
    nop(0,'0,0); nop(0,'0,0); nop(1,9'h0D3,0);
    // flush a long op
    v(0,0,0, 0,13'd0,'0, 1,l,9'h0E1, 0,1, 0,'0,0);
    nop(0,'0,0); nop(0,'0,0);
    v(0,1,0, 0,13'd0,'0, 0,13'd0,'0, 0,0, 0,'0,0);
    v(0,0,0, 1,s,9'h0E2, 0,13'd0,'0, 1,0, 0,'0,0);
    nop(0,'0,0); nop(0,'0,0); nop(1,9'h0E2,0);
    for (int i = 0; i < LONG_LAT; i++) nop(0,'0,0);
    // reset in the middle of a long op restores slot-0 priority
    v(0,0,0, 1,l,9'h0F1, 0,13'd0,'0, 1,0, 0,'0,0);
    nop(0,'0,0); nop(0,'0,0);
    v(1,0,0, 1,s,9'h0F2, 1,13'h0A5,9'h0F3, 0,0, 0,'0,0);
    v(0,0,0, 1,s,9'h0F2, 1,13'h0A5,9'h0F3, 1,0, 0,'0,0);
    v(0,0,0, 1,s,9'h0F4, 1,13'h0A5,9'h0F3, 0,1, 0,'0,0);
    v(0,0,0, 1,s,9'h0F4, 0,13'd0,'0, 1,0, 0,'0,0);
    nop(1,9'h0F2,0); nop(1,9'h0F3,1); nop(1,9'h0F4,0);
    for (int i = 0; i < LONG_LAT; i++) nop(0,'0,0);
  endtask

  // ---------------- reference model ----------------
  // Each accepted op is a record due at an enabled-cycle count; the unit is
  // "idle" once nothing short remains behind the leaving result.
  typedef struct { logic [TAGW-1:0] tag; logic src; bit is_long; int due; } fl_t;
  fl_t infl[$];
  int  ecount;
  bit  m_ptr, m_idle, m_wait, m_wslot;

  logic            h_v   [2];
  logic [12:0]     h_op  [2];
  logic [TAGW-1:0] h_tag [2];
  logic            r_stall, r_flush;

  function automatic bit is_long_op(input logic [12:0] op);
    return op[7:0] == LONG_OPC;
  endfunction

  task automatic new_req(input int s);
    logic [12:0] op;
    op = 13'($urandom_range(0, 8191));
    if ($urandom_range(0, 6) == 0) op[7:0] = LONG_OPC;
    else if (op[7:0] == LONG_OPC) op[0] = ~op[0];
    h_v[s]   = 1'b1;
    h_op[s]  = op;
    h_tag[s] = TAGW'($urandom_range(0, (1 << TAGW) - 1));
  endtask

  task automatic drive_rand();
    for (int s = 0; s < 2; s++)
      if (!h_v[s] && $urandom_range(0, 2) != 0) new_req(s);
    r_stall  = ($urandom_range(0, 5) == 0);
    r_flush  = ($urandom_range(0, 39) == 0);
    req0_vld = h_v[0]; req0_op = h_op[0]; req0_tag = h_tag[0];
    req1_vld = h_v[1]; req1_op = h_op[1]; req1_tag = h_tag[1];
    wb_stall = r_stall; flush = r_flush;
  endtask

  task automatic model_step(output int grant);
    bit long_busy, short_after, set_wait, wv, ws, lg;
    int w;
    logic [TAGW-1:0] wt;
    long_busy = 0; short_after = 0; set_wait = 0; wv = 0; ws = 0; wt = '0;
    grant = -1;
    foreach (infl[i]) begin
      if (infl[i].is_long) long_busy = 1;
      else if (infl[i].due > ecount) short_after = 1;
      if (infl[i].due == ecount) begin wv = 1; wt = infl[i].tag; ws = infl[i].src; end
    end
    if (!r_stall && !r_flush && !long_busy) begin
      if (m_wait) begin
        if (!short_after && h_v[m_wslot] && is_long_op(h_op[m_wslot])) grant = int'(m_wslot);
      end else if (h_v[0] || h_v[1]) begin
        w = (h_v[0] && h_v[1]) ? int'(m_ptr) : (h_v[1] ? 1 : 0);
        if (!is_long_op(h_op[w]) || m_idle) grant = w;
        else set_wait = 1;
      end
    end
    chk_all("rand", grant == 0, grant == 1, (grant >= 0) ? h_op[grant] : 13'd0, wv, wt, ws);
    // advance the model across the coming clock edge
    if (r_flush) begin
      infl.delete();
      m_idle = 1; m_wait = 0;
    end else if (!r_stall) begin
      for (int i = infl.size() - 1; i >= 0; i--)
        if (infl[i].due == ecount) begin
          if (infl[i].is_long) m_idle = 1;
          infl.delete(i);
        end
      if (grant >= 0) begin
        lg = is_long_op(h_op[grant]);
        infl.push_back('{tag: h_tag[grant], src: grant[0], is_long: lg,
                         due: ecount + (lg ? LONG_LAT : LAT)});
        m_ptr  = ~grant[0];
        m_idle = 0;
        m_wait = 0;
      end else if (set_wait) begin
        m_wait  = 1;
        m_wslot = (h_v[0] && h_v[1]) ? m_ptr : h_v[1];
      end else if (!m_wait && !long_busy && !short_after) begin
        m_idle = 1;
      end
    end
    if (!r_stall) ecount++;
  endtask

  // ---------------- main ----------------
  initial begin
    int g;
    rst = 1; flush = 0; wb_stall = 0;
    req0_vld = 1; req0_op = 13'h001; req0_tag = 9'h011;
    req1_vld = 1; req1_op = 13'h002; req1_tag = 9'h022;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all("reset", 0, 0, 13'd0, 0, '0, 0);
    chk("reset.clken", {31'd0, mul_clkEn}, 32'd1);
    @(posedge clk); #1;

    build_table();
    foreach (vecs[i]) begin
      rst = vecs[i].rs; flush = vecs[i].fl; wb_stall = vecs[i].st;
      req0_vld = vecs[i].v0; req0_op = vecs[i].o0; req0_tag = vecs[i].t0;
      req1_vld = vecs[i].v1; req1_op = vecs[i].o1; req1_tag = vecs[i].t1;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].er0, vecs[i].er1,
              vecs[i].er0 ? vecs[i].o0 : (vecs[i].er1 ? vecs[i].o1 : 13'd0),
              vecs[i].ewv, vecs[i].ewt, vecs[i].ews);
      if (vecs[i].st) chk($sformatf("vec%0d.clken", i), {31'd0, mul_clkEn}, 32'd0);
      @(posedge clk); #1;
    end

    rst = 1; flush = 0; wb_stall = 0; req0_vld = 0; req1_vld = 0;
    @(posedge clk); #1;
    rst = 0;
    infl.delete();
    ecount = 0; m_ptr = 0; m_idle = 1; m_wait = 0; m_wslot = 0;
    h_v[0] = 0; h_v[1] = 0;
    drive_rand();
    for (int c = 0; c < N_RAND; c++) begin
      @(negedge clk);
      model_step(g);
      @(posedge clk); #1;
      if (g >= 0) h_v[g] = 1'b0;
      drive_rand();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
